// File: rtl/mul4_rr_sched.sv
// Round-robin arbiter sharing one external 4x4 signed multiplier among
// N_REQ requesters; one job in flight, response returned with owner ID.
module mul4_rr_sched #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [4*N_REQ-1:0] req_a,
    input  logic [4*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic [3:0]         mul_a,
    output logic [3:0]         mul_b,
    input  logic [7:0]         mul_p,
    output logic               rsp_valid,
    output logic [ID_W-1:0]    rsp_id,
    output logic [7:0]         rsp_p,
    input  logic               rsp_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      op_a_q, op_a_d;
    logic [3:0]      op_b_q, op_b_d;
    logic [ID_W-1:0] cur_id_q, cur_id_d;
    logic [ID_W-1:0] last_id_q, last_id_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [7:0]      rsp_p_q, rsp_p_d;

    logic            found;
    int              sel_i;
    int              idx;
    logic [N_REQ-1:0] vld_sh;

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        found  = 1'b0;
        sel_i  = 0;
        idx    = 0;
        vld_sh = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx    = (int'(last_id_q) + k) % N_REQ;
            vld_sh = req_valid >> idx;
            if (vld_sh[0]) begin
                found = 1'b1;
                sel_i = idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        cur_id_d  = cur_id_q;
        last_id_d = last_id_q;
        rsp_id_d  = rsp_id_q;
        rsp_p_d   = rsp_p_q;
        req_ready = '0;
        unique case (state_q)
            S_IDLE: begin
                if (found && !rst) begin
                    req_ready = N_REQ'(1) << sel_i;
                    op_a_d    = 4'(req_a >> (4 * sel_i));
                    op_b_d    = 4'(req_b >> (4 * sel_i));
                    cur_id_d  = ID_W'(sel_i);
                    last_id_d = ID_W'(sel_i);
                    state_d   = S_CALC;
                end
            end
            S_CALC: begin
                rsp_p_d  = mul_p;
                rsp_id_d = cur_id_q;
                state_d  = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            cur_id_q  <= '0;
            last_id_q <= ID_W'(N_REQ - 1);
            rsp_id_q  <= '0;
            rsp_p_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            cur_id_q  <= cur_id_d;
            last_id_q <= last_id_d;
            rsp_id_q  <= rsp_id_d;
            rsp_p_q   <= rsp_p_d;
        end
    end

    assign mul_a     = op_a_q;
    assign mul_b     = op_b_q;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_p     = rsp_p_q;

endmodule
